// File: rtl/reset_seq.sv
// Power-on / request / watchdog reset sequencer: stretches a reset over STRETCH
// ticks, then releases CHANNELS domains one by one, STAGGER ticks apart.
module reset_seq #(
   parameter int DIV_LOG2 = 4,
   parameter int STRETCH  = 5,
   parameter int CHANNELS = 2,
   parameter int STAGGER  = 2,
   parameter int PERIOD_W = 12
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req,
   input  logic                periodic_en,
   input  logic                kick,
   output logic                ce,
   output logic [CHANNELS-1:0] rst_out,
   output logic                busy,
   output logic [1:0]          cause
);

   localparam int ST_W = (STRETCH > 1) ? $clog2(STRETCH) : 1;
   localparam int SG_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [1:0] CAUSE_REQ = 2'd1;
   localparam logic [1:0] CAUSE_WDT = 2'd2;

   typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

   state_t                state, state_nx;
   logic [ST_W-1:0]       stretch_cnt, stretch_nx;
   logic [SG_W-1:0]       stag_cnt, stag_nx;
   logic [CH_W-1:0]       ch, ch_nx;
   logic [PERIOD_W-1:0]   per_cnt, per_nx;
   logic [CHANNELS-1:0]   rst_nx;
   logic [1:0]            cause_nx;
   logic                  tick;
   logic                  timeout;

   // tick is the prescaler wrap; ce is its registered copy, so every counter
   // advances on the same edge that ce rises.
   generate
      if (DIV_LOG2 == 0) begin : g_nodiv
         assign tick = 1'b1;
      end else begin : g_div
         logic [DIV_LOG2-1:0] pre;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) pre <= '0;
            else        pre <= pre + DIV_LOG2'(1);
         end
         assign tick = &pre;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ce <= 1'b0;
      else        ce <= tick;
   end

   assign timeout = (state == RUN) && tick && periodic_en && (&per_cnt);

   always_comb begin
      state_nx   = state;
      stretch_nx = stretch_cnt;
      stag_nx    = stag_cnt;
      ch_nx      = ch;
      rst_nx     = rst_out;
      cause_nx   = cause;
      per_nx     = per_cnt;

      if (kick)
         per_nx = '0;
      else if (state == RUN && periodic_en && tick)
         per_nx = per_cnt + PERIOD_W'(1);

      unique case (state)
         HOLD: begin
            rst_nx = '1;
            if (tick) begin
               if (stretch_cnt == ST_W'(STRETCH - 1)) begin
                  stretch_nx = '0;
                  stag_nx    = '0;
                  ch_nx      = CH_W'(1);
                  rst_nx[0]  = 1'b0;
                  state_nx   = (CHANNELS == 1) ? RUN : RELEASE;
               end else begin
                  stretch_nx = stretch_cnt + ST_W'(1);
               end
            end
         end
         RELEASE: begin
            if (tick) begin
               if (stag_cnt == SG_W'(STAGGER - 1)) begin
                  stag_nx    = '0;
                  rst_nx[ch] = 1'b0;
                  if (ch == CH_W'(CHANNELS - 1)) state_nx = RUN;
                  else                           ch_nx    = ch + CH_W'(1);
               end else begin
                  stag_nx = stag_cnt + SG_W'(1);
               end
            end
         end
         default: ;
      endcase

      // Re-entry into HOLD; req is applied last so it wins a same-edge timeout.
      if (timeout || req) begin
         state_nx   = HOLD;
         rst_nx     = '1;
         stretch_nx = '0;
         stag_nx    = '0;
         ch_nx      = '0;
         per_nx     = '0;
         cause_nx   = req ? CAUSE_REQ : CAUSE_WDT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HOLD;
         stretch_cnt <= '0;
         stag_cnt    <= '0;
         ch          <= '0;
         per_cnt     <= '0;
         rst_out     <= '1;
         cause       <= 2'd0;
      end else begin
         state       <= state_nx;
         stretch_cnt <= stretch_nx;
         stag_cnt    <= stag_nx;
         ch          <= ch_nx;
         per_cnt     <= per_nx;
         rst_out     <= rst_nx;
         cause       <= cause_nx;
      end
   end

   assign busy = |rst_out;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: fixed vector table, hand-written corner sequences and a
// random run, all against an elapsed-ticks reference model.
module tb_reset_seq;
   localparam int DIV_LOG2 = 2;
   localparam int STRETCH  = 5;
   localparam int CHANNELS = 3;
   localparam int STAGGER  = 2;
   localparam int PERIOD_W = 4;
   localparam int REL_END  = STRETCH + STAGGER * (CHANNELS - 1);
   localparam int WD_MAX   = (1 << PERIOD_W) - 1;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                req = 1'b0;
   logic                periodic_en = 1'b0;
   logic                kick = 1'b0;
   logic                ce;
   logic [CHANNELS-1:0] rst_out;
   logic                busy;
   logic [1:0]          cause;

   reset_seq #(
      .DIV_LOG2(DIV_LOG2), .STRETCH(STRETCH), .CHANNELS(CHANNELS),
      .STAGGER(STAGGER), .PERIOD_W(PERIOD_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .periodic_en(periodic_en),
      .kick(kick), .ce(ce), .rst_out(rst_out), .busy(busy), .cause(cause)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: edges since reset, ticks elapsed since the hold began, watchdog count.
   int         m_n, m_el, m_wd;
   logic       m_ce;
   logic [1:0] m_cause;

   function automatic logic [CHANNELS-1:0] m_rst();
      logic [CHANNELS-1:0] r;
      for (int k = 0; k < CHANNELS; k++) r[k] = (m_el < STRETCH + STAGGER * k);
      return r;
   endfunction

   task automatic model_reset();
      m_n = 0; m_el = 0; m_wd = 0; m_ce = 1'b0; m_cause = 2'd0;
   endtask

   task automatic model_edge(input logic r, input logic p, input logic k);
      bit tk, run, to;
      m_n++;
      tk   = (m_n % (1 << DIV_LOG2)) == 0;
      run  = m_el >= REL_END;
      to   = run && tk && p && (m_wd == WD_MAX);
      m_ce = tk;
      if (r) begin
         m_el = 0; m_wd = 0; m_cause = 2'd1;
      end else if (to) begin
         m_el = 0; m_wd = 0; m_cause = 2'd2;
      end else begin
         if (k) m_wd = 0;
         else if (run && p && tk) m_wd++;
         if (!run && tk) m_el++;
      end
   endtask

   // Drive at negedge, let one posedge happen, compare with the model at negedge.
   task automatic step(input logic r, input logic p, input logic k);
      logic [CHANNELS+3:0] exp_v, act_v;
      req = r; periodic_en = p; kick = k;
      @(posedge clk);
      model_edge(r, p, k);
      @(negedge clk);
      exp_v = {m_ce, m_rst(), |m_rst(), m_cause};
      act_v = {ce, rst_out, busy, cause};
      checks++;
      if (act_v !== exp_v) begin
         errors++;
         $display("FAIL model edge=%0d {ce,rst_out,busy,cause} got=%b want=%b",
                  m_n, act_v, exp_v);
      end
   endtask

   task automatic check_now(input string name, input logic [CHANNELS+3:0] want);
      logic [CHANNELS+3:0] got;
      got = {ce, rst_out, busy, cause};
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s {ce,rst_out,busy,cause} got=%b want=%b", name, got, want);
      end
   endtask

   typedef struct {
      int                  cyc;
      logic                r, p, k;
      logic                ce;
      logic [CHANNELS-1:0] rst;
      logic                busy;
      logic [1:0]          cause;
   } row_t;

   row_t tbl[$];

   function automatic void add(int cyc, logic r, logic p, logic k, logic c,
                               logic [CHANNELS-1:0] rs, logic b, logic [1:0] ca);
      row_t e;
      e.cyc = cyc; e.r = r; e.p = p; e.k = k;
      e.ce = c; e.rst = rs; e.busy = b; e.cause = ca;
      tbl.push_back(e);
   endfunction

   initial begin
      bit kick_ok;

      // Comments give the edge count since rst_n rose, after each row.
      add(19, 0, 0, 0, 0, 3'b111, 1, 0); // 19
      add( 1, 0, 0, 0, 1, 3'b110, 1, 0); // 20 rst_out[0] falls
      add( 8, 0, 0, 0, 1, 3'b100, 1, 0); // 28
      add( 8, 0, 0, 0, 1, 3'b000, 0, 0); // 36 run
      add(63, 0, 1, 0, 0, 3'b000, 0, 0); // 99 watchdog at 15
      add( 1, 0, 1, 0, 1, 3'b111, 1, 2); // 100 timeout on 16th tick
      add(20, 0, 0, 0, 1, 3'b110, 1, 2); // 120
      add( 8, 0, 0, 0, 1, 3'b100, 1, 2); // 128
      add( 8, 0, 0, 0, 1, 3'b000, 0, 2); // 136
      add( 1, 1, 0, 0, 0, 3'b111, 1, 1); // 137 one-cycle req
      add(18, 0, 0, 0, 0, 3'b111, 1, 1); // 155
      add( 1, 0, 0, 0, 1, 3'b110, 1, 1); // 156
      add(16, 0, 0, 0, 1, 3'b000, 0, 1); // 172
      add(40, 1, 0, 0, 1, 3'b111, 1, 1); // 212 req held 40 clk
      add(19, 0, 0, 0, 0, 3'b111, 1, 1); // 231
      add( 1, 0, 0, 0, 1, 3'b110, 1, 1); // 232 5th tick after req fell
      add(16, 0, 0, 0, 1, 3'b000, 0, 1); // 248
      add(63, 0, 1, 0, 0, 3'b000, 0, 1); // 311 watchdog at 15
      add( 1, 1, 1, 0, 1, 3'b111, 1, 1); // 312 req collides with timeout
      add(24, 0, 0, 0, 1, 3'b110, 1, 1); // 336 mid-release

      model_reset();
      repeat (3) @(negedge clk);
      check_now("reset_state", {1'b0, 3'b111, 1'b1, 2'd0});
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         repeat (tbl[i].cyc) step(tbl[i].r, tbl[i].p, tbl[i].k);
         check_now($sformatf("row%0d", i),
                   {tbl[i].ce, tbl[i].rst, tbl[i].busy, tbl[i].cause});
      end

      // Async reset between edges, while in RELEASE.
      #2 rst_n = 1'b0;
      #1 check_now("async_reset", {1'b0, 3'b111, 1'b1, 2'd0});
      model_reset();
      @(negedge clk);
      check_now("async_reset_hold", {1'b0, 3'b111, 1'b1, 2'd0});
      rst_n = 1'b1;

      // Kick every 8 ticks for 200 ticks in RUN keeps the domains released.
      repeat (36) step(0, 1, 0);
      kick_ok = 1'b1;
      for (int i = 0; i < 200 * 4; i++) begin
         step(0, 1, (i % 32) == 0);
         if (rst_out !== 3'b000 || busy !== 1'b0) kick_ok = 1'b0;
      end
      checks++;
      if (!kick_ok) begin
         errors++;
         $display("FAIL kick_hold rst_out/busy left 0 during kicked run (got rst_out=%b busy=%b)",
                  rst_out, busy);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(63) == 0, $urandom_range(7) != 0, $urandom_range(39) == 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL expose these parameters (name, default, meaning):
- DIV_LOG2, 4: tick divider; ce pulses once per 2^DIV_LOG2 clk cycles.
- STRETCH, 5: hold length, in ce ticks.
- CHANNELS, 2: number of reset domains released in sequence.
- STAGGER, 2: ce ticks between successive channel releases.
- PERIOD_W, 12: width of the periodic-reset (watchdog) counter.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- rst_n, in, 1: async active-low reset.
- req, in, 1: synchronous reset request, level-sensitive.
- periodic_en, in, 1: enables the periodic-reset counter.
- kick, in, 1: clears the periodic-reset counter.
- ce, out, 1: single-clk clock-enable tick.
- rst_out, out, CHANNELS: active-high per-domain resets.
- busy, out, 1: high while any rst_out bit is high.
- cause, out, 2: last reset cause; 0 = power-on, 1 = req, 2 = periodic timeout.

Function
REQ-004 The prescaler SHALL count clk cycles modulo 2^DIV_LOG2 in all states and assert ce for exactly one clk when it wraps; ce is registered.
REQ-005 When DIV_LOG2=0, ce SHALL be constant 1 from the first clk edge after reset release.
REQ-006 The FSM SHALL have three states: HOLD, RELEASE, RUN. All stretch, stagger and channel counters SHALL advance only on ce.
REQ-007 HOLD: all rst_out=1. On the STRETCH-th ce, rst_out[0] SHALL clear on the same edge and the FSM SHALL go to RELEASE (or to RUN if CHANNELS=1).
REQ-008 RELEASE: rst_out[k] SHALL clear on the edge of the ce that falls STAGGER*k ticks after rst_out[0] cleared. The FSM SHALL enter RUN on the edge that clears rst_out[CHANNELS-1].
REQ-009 busy SHALL be the OR of rst_out, so it is 0 only in RUN.
REQ-010 Periodic counter behaviour:
- In RUN with periodic_en=1, the counter SHALL increment on each ce.
- kick=1 SHALL clear it, with priority over increment.
- periodic_en=0 SHALL freeze the counter without clearing it.
REQ-011 Timeout SHALL occur when the counter equals 2^PERIOD_W-1 and ce=1 in RUN. On timeout the FSM SHALL go to HOLD, set all rst_out=1, and set cause=2.
REQ-012 req=1 sampled on any edge SHALL force HOLD, all rst_out=1, stretch count cleared, and cause=1.
- req held high SHALL keep the stretch count at 0, so the hold is extended.
- Stretch counting SHALL begin on the first ce after req falls.
REQ-013 When req and timeout occur on the same edge, req SHALL win and cause SHALL be 1.
REQ-014 Entering HOLD by any route SHALL clear the periodic counter and the stagger counter.
REQ-015 The block SHALL be free of combinational paths from inputs to outputs.

Reset
REQ-016 rst_n=0 SHALL asynchronously force the following, regardless of state or of any sequence in progress:
- FSM = HOLD.
- rst_out = all 1s.
- busy = 1.
- ce = 0.
- cause = 0.
- Prescaler, stretch, stagger and periodic counters = 0.
REQ-017 After rst_n rises, operation SHALL begin on the next clk edge. cause SHALL hold its value until the next req or timeout.

Verification
Bench parameters: DIV_LOG2=2, STRETCH=5, CHANNELS=3, STAGGER=2, PERIOD_W=4.
REQ-018 Power-on: release rst_n, hold req=0 -> ce high on clk cycles 4, 8, 12, ...; rst_out[0] falls at cycle 20, rst_out[1] at 28, rst_out[2] at 36; busy falls at 36; cause=0.
REQ-019 Timeout: periodic_en=1, kick=0 in RUN -> on the 16th ce in RUN, rst_out=3'b111 and cause=2; the release sequence then repeats with the same 20/28/36-cycle spacing.
REQ-020 Kick: pulse kick every 8 ce in RUN for 200 ce -> rst_out stays 3'b000 and busy stays 0.
REQ-021 Request: 1-clk req pulse in RUN -> rst_out=3'b111, busy=1, cause=1 on the next edge. Hold req high for 40 clk -> rst_out[0] stays 1 until the 5th ce after req falls.
REQ-022 Collision: assert req on the same edge as a timeout -> cause=1, not 2.
REQ-023 Async reset mid-sequence: assert rst_n=0 between clk edges while in RELEASE -> rst_out=3'b111, ce=0, cause=0 immediately, without waiting for a clk edge.
